// File: rtl/sys_array_pkg.sv
// Shared defaults and width helpers for the systolic-array result collector.
package sys_array_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ARRAY_W    = 4;
    localparam int DEF_FIFO_DEPTH = 8;

    // Width of one result lane: a full product/accumulation of two operands.
    function automatic int res_w(input int dw);
        return 2 * dw;
    endfunction

    // Occupancy counter width, able to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_COUNT_W = cnt_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/sys_array_fifo.sv
// Generic synchronous first-word-fall-through FIFO with synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sys_array_fifo
    import sys_array_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [CW-1:0]    count_nxt_s;

    // Qualify requests against occupancy and derive the next occupancy.
    always_comb begin
        pop_ok_s    = pop & ~empty_r;
        push_ok_s   = push & (~full_r | pop_ok_s);
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and status flags; clear discards any transfer this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    // Storage array; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) mem_r[k] <= '0;
        end else if (push_ok_s && !clr) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/sys_array_out_collector.sv
// De-skews the staggered result lanes of the systolic array into one aligned
// vector and buffers it for a valid/ready consumer. The array cannot stall, so
// a vector arriving at a full buffer is dropped and recorded in a sticky flag.
module sys_array_out_collector
    import sys_array_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ARRAY_W    = DEF_ARRAY_W,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int RW         = res_w(DATA_WIDTH),
    localparam int VW         = RW * ARRAY_W,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             row0_valid,
    input  logic [VW-1:0]    array_out,
    output logic [VW-1:0]    res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [VW-1:0] aligned_s;
    logic          push_v_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          overflow_r;

    // Lane i is i cycles late, so it is delayed by ARRAY_W-1-i to line up with the last lane.
    for (genvar i = 0; i < ARRAY_W; i++) begin : g_lane
        localparam int DLY = ARRAY_W - 1 - i;
        if (DLY == 0) begin : g_pass
            assign aligned_s[i*RW +: RW] = array_out[i*RW +: RW];
        end else begin : g_dly
            logic [RW-1:0] pipe_r [DLY];
            // Lane delay chain; data needs no flush since the valid pipe gates it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < DLY; k++) pipe_r[k] <= '0;
                end else begin
                    pipe_r[0] <= array_out[i*RW +: RW];
                    for (int k = 1; k < DLY; k++) pipe_r[k] <= pipe_r[k-1];
                end
            end
            assign aligned_s[i*RW +: RW] = pipe_r[DLY-1];
        end
    end

    if (ARRAY_W == 1) begin : g_vnone
        assign push_v_s = row0_valid;
    end else begin : g_vpipe
        logic [ARRAY_W-2:0] vpipe_r;
        // Valid marker travels alongside lane 0; flush kills every in-flight vector.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vpipe_r <= '0;
            end else if (flush) begin
                vpipe_r <= '0;
            end else begin
                vpipe_r[0] <= row0_valid;
                for (int k = 1; k < ARRAY_W - 1; k++) vpipe_r[k] <= vpipe_r[k-1];
            end
        end
        assign push_v_s = vpipe_r[ARRAY_W-2];
    end

    assign pop_s = res_ready & ~empty_s;

    sys_array_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .push    (push_v_s),
        .pop     (res_ready),
        .wdata   (aligned_s),
        .rdata   (res_data),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count)
    );

    // Sticky drop flag: set when an aligned vector meets a full FIFO with no pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (push_v_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign res_valid = ~empty_s;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_sys_array_out_collector.sv
// Self-checking bench: a directed table, hand-written corner sequences and a
// random run, all compared against a queue-based reference of the collector.
module tb_sys_array_out_collector;

    localparam int A     = 4;
    localparam int RW    = 16;
    localparam int VW    = 64;
    localparam int DEPTH = 8;
    localparam int HMAX  = 4096;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          row0_valid = 1'b0;
    logic [VW-1:0] array_out = '0;
    logic [VW-1:0] res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [3:0]    count;
    logic          overflow;

    sys_array_out_collector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .row0_valid (row0_valid),
        .array_out  (array_out),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: buffered vectors, sticky flag, per-cycle input history.
    logic [VW-1:0] q[$];
    logic          m_ovf = 1'b0;
    int            cyc = 0;
    int            reset_base = 0;
    logic          hist_v  [HMAX];
    logic          hist_fl [HMAX];
    logic [VW-1:0] hist_ao [HMAX];
    logic          cur_fl, cur_rdy, e_valid, m_push;
    logic [VW-1:0] m_vec;

    typedef struct {
        logic          v;
        logic [VW-1:0] ao;
        logic          rdy;
        logic          ev;
        int            ecnt;
        logic          eovf;
        logic [VW-1:0] edata;
    } row_t;
    row_t tbl[7];

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // A vector launched at T lands in the buffer at T+A-1 unless reset or a flush intervened.
    task automatic model_arrival(input int c);
        int t;
        t = c - (A - 1);
        m_push = 1'b0;
        m_vec  = '0;
        if (t >= reset_base && hist_v[t]) begin
            m_push = 1'b1;
            for (int k = t; k < c; k++) if (hist_fl[k]) m_push = 1'b0;
            for (int i = 0; i < A; i++) m_vec[i*RW +: RW] = hist_ao[t+i][i*RW +: RW];
        end
    endtask

    task automatic step_pre(input logic v, input logic [VW-1:0] ao, input logic fl, input logic rdy);
        row0_valid = v;
        array_out  = ao;
        flush      = fl;
        res_ready  = rdy;
        cur_fl     = fl;
        cur_rdy    = rdy;
        hist_v[cyc]  = v;
        hist_ao[cyc] = ao;
        hist_fl[cyc] = fl;
        e_valid = (q.size() > 0);
        model_arrival(cyc);
        #4;
        chk("res_valid", VW'(res_valid), VW'(e_valid));
        chk("count", VW'(count), VW'(q.size()));
        chk("overflow", VW'(overflow), VW'(m_ovf));
        if (e_valid) chk("res_data", res_data, q[0]);
    endtask

    task automatic step_post();
        if (cur_fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (e_valid && cur_rdy) void'(q.pop_front());
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(m_vec);
                else m_ovf = 1'b1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [VW-1:0] ao, input logic fl, input logic rdy);
        step_pre(v, ao, fl, rdy);
        step_post();
    endtask

    function automatic logic [VW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Lane i of vector k (launched at cycle k) is 16*k+i, placed on cycle k+i.
    function automatic logic [VW-1:0] stag(input int c, input int nvec);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < A; i++)
            if (c - i >= 0 && c - i < nvec) r[i*RW +: RW] = RW'(16 * (c - i) + i);
        return r;
    endfunction

    task automatic do_reset();
        row0_valid = 1'b0;
        flush      = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", VW'(res_valid), VW'(1'b0));
        chk("rst_count", VW'(count), VW'(0));
        chk("rst_overflow", VW'(overflow), VW'(1'b0));
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        m_ovf = 1'b0;
        cyc += 3;
        reset_base = cyc;
    endtask

    initial begin
        for (int k = 0; k < HMAX; k++) begin
            hist_v[k] = 1'b0; hist_fl[k] = 1'b0; hist_ao[k] = '0;
        end
        // Power-on reset
        #12;
        chk("por_valid", VW'(res_valid), VW'(1'b0));
        chk("por_count", VW'(count), VW'(0));
        chk("por_overflow", VW'(overflow), VW'(1'b0));
        chk("por_data", res_data, 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single vector: lanes 100..103 skewed by one cycle each
        for (int c = 0; c < 7; c++) begin
            tbl[c].v     = (c == 0);
            tbl[c].ao    = '0;
            if (c < A) tbl[c].ao[c*RW +: RW] = RW'(100 + c);
            tbl[c].rdy   = 1'b1;
            tbl[c].ev    = (c == 4);
            tbl[c].ecnt  = (c == 4) ? 1 : 0;
            tbl[c].eovf  = 1'b0;
            tbl[c].edata = {16'd103, 16'd102, 16'd101, 16'd100};
        end
        for (int c = 0; c < 7; c++) begin
            step_pre(tbl[c].v, tbl[c].ao, 1'b0, tbl[c].rdy);
            chk("tbl_valid", VW'(res_valid), VW'(tbl[c].ev));
            chk("tbl_count", VW'(count), VW'(tbl[c].ecnt));
            chk("tbl_overflow", VW'(overflow), VW'(tbl[c].eovf));
            if (tbl[c].ev) chk("tbl_data", res_data, tbl[c].edata);
            step_post();
        end

        // Four back-to-back vectors, consumer always ready
        for (int c = 0; c < 10; c++) step(c < 4, stag(c, 4), 1'b0, 1'b1);

        // Nine vectors into a stalled consumer, then drain
        for (int c = 0; c < 14; c++) begin
            step_pre(c < 9, stag(c, 9), 1'b0, 1'b0);
            if (c == 13) begin
                chk("sat_count", VW'(count), VW'(8));
                chk("sat_overflow", VW'(overflow), VW'(1'b1));
            end
            step_post();
        end
        for (int c = 0; c < 12; c++) step(1'b0, '0, 1'b0, 1'b1);
        step_pre(1'b0, '0, 1'b1, 1'b0);
        chk("drain_overflow", VW'(overflow), VW'(1'b1));
        step_post();

        // Full buffer with simultaneous push and pop
        for (int c = 0; c < 14; c++) begin
            step_pre(c <= 8, rnd64(), 1'b0, c == 11);
            if (c == 11) chk("full_count", VW'(count), VW'(8));
            if (c == 12) begin
                chk("pp_count", VW'(count), VW'(8));
                chk("pp_overflow", VW'(overflow), VW'(1'b0));
            end
            step_post();
        end
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b0, 1'b1);

        // Flush in the cycle a fourth vector arrives
        for (int c = 0; c < 12; c++) begin
            step_pre(c < 4, stag(c, 4), c == 6, c > 6);
            if (c == 6) chk("preflush_count", VW'(count), VW'(3));
            if (c == 7) begin
                chk("flush_count", VW'(count), VW'(0));
                chk("flush_valid", VW'(res_valid), VW'(1'b0));
                chk("flush_overflow", VW'(overflow), VW'(1'b0));
            end
            step_post();
        end

        // Asynchronous reset mid-stream with entries buffered and vectors in flight
        for (int c = 0; c < 7; c++) step(1'b1, rnd64(), 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 10; c++) step(1'b0, rnd64(), 1'b0, 1'b1);

        // Random traffic against the reference
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 99) < 55, rnd64(), $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 55);
        for (int c = 0; c < 12; c++) step(1'b0, '0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_array_out_collector.md
Name: sys_array_out_collector

Overview:
Receiving end of the systolic array's result interface.
- The array emits one 2*DATA_WIDTH partial-sum lane per row, with no stall capability.
- Row i's result for a given input vector appears i cycles after row 0's.
- This block de-skews the lanes into one aligned result vector, buffers vectors in a FIFO, and presents them downstream on a valid/ready handshake.
- It sits between the array's out_module bus and the result consumer (writeback or DMA).

Parameters:
DATA_WIDTH, 8, operand width; each result lane is 2*DATA_WIDTH bits.
ARRAY_W, 4, number of array rows, i.e. number of result lanes (>=1).
FIFO_DEPTH, 8, result-vector FIFO entries (power of two, >=2).

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of the de-skew valid pipe, the FIFO and overflow.
row0_valid  in  1  array lane 0 carries a valid result this cycle; lane i is valid i cycles later.
array_out  in  2*DATA_WIDTH*ARRAY_W  array result lanes; lane i = bits [2*DATA_WIDTH*(i+1)-1 : 2*DATA_WIDTH*i].
res_data  out  2*DATA_WIDTH*ARRAY_W  aligned result vector at the FIFO head, same lane packing.
res_valid  out  1  FIFO not empty.
res_ready  in  1  consumer accepts res_data.
count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
overflow  out  1  sticky flag: an aligned vector was dropped because the FIFO was full.

Behaviour:
- Reset (async, reset_n=0):
  - All de-skew registers, the valid pipe, the FIFO pointers, count and overflow go to 0.
  - res_valid=0 and res_data=0 immediately.
  - In-flight vectors are lost.
- De-skew:
  - Lane i passes through ARRAY_W-1-i registers; lane ARRAY_W-1 is combinational pass-through.
  - row0_valid passes through ARRAY_W-1 registers to form push_v.
  - If row0_valid is high in cycle T, every lane is aligned at the chain outputs in cycle T+ARRAY_W-1, and push_v is high in that cycle.
- Latency: with the FIFO empty, res_valid=1 and res_data is valid in cycle T+ARRAY_W (ARRAY_W=1 gives T+1).
- Throughput: one vector per cycle sustained; row0_valid may be high on consecutive cycles.
- FIFO:
  - First-word-fall-through: res_data shows the head entry whenever res_valid=1.
  - Pop occurs when res_valid & res_ready.
  - Push occurs when push_v & (not full or pop this cycle): a simultaneous push and pop at full is legal and leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - res_data is don't-care when res_valid=0; the bench must not check it.
- Overflow:
  - If push_v=1, the FIFO is full and there is no pop, the vector is dropped and overflow is set.
  - overflow stays set until flush or reset.
  - The array is never back-pressured.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flush (synchronous, highest priority):
  - Next cycle: count=0, res_valid=0, overflow=0, valid pipe cleared.
  - A push or pop in the flush cycle is discarded and does not set overflow.
  - De-skew data registers need not clear; only the valid pipe does.
- Arithmetic: none. Lanes pass bit-exact with no truncation or sign handling.
- res_ready high while res_valid=0: no effect, count does not underflow.

Decomposition:
- Package sys_array_pkg holds:
  - default DATA_WIDTH, ARRAY_W and FIFO_DEPTH;
  - function res_w(dw) = 2*dw;
  - the count width expression $clog2(FIFO_DEPTH+1).
- One sub-module: sys_array_fifo. It is a generic synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, and the same asynchronous active-low reset. Flush is routed to its synchronous clear.
- The de-skew generate loop stays in the top module.

Test Plan:
1. ARRAY_W=4, DATA_WIDTH=8, res_ready=1: row0_valid at T, lane i = 100+i in cycle T+i -> res_valid only in cycle T+4, res_data lanes {100,101,102,103}, count returns to 0 at T+5.
2. Four back-to-back vectors (row0_valid high T..T+3, lane i of vector k = 16*k+i), res_ready=1 -> res_valid high T+4..T+7, vectors in order, count never exceeds 1, overflow=0.
3. res_ready=0, nine vectors pushed -> count saturates at 8, overflow=1 after the ninth. Then res_ready=1 -> exactly eight vectors drain in order (vectors 0..7), overflow stays 1.
4. FIFO full (count=8) with res_ready=1 and push_v=1 in the same cycle -> count stays 8, overflow stays 0, head advances by one vector.
5. Three entries buffered, flush=1 in a cycle where push_v=1 -> next cycle count=0, res_valid=0, overflow=0; the flushed-cycle vector never appears.
6. reset_n dropped asynchronously mid-stream, between clock edges, with entries buffered -> res_valid, count and overflow drop to 0 without waiting for an edge. After release with row0_valid=0, no stale vector ever appears.
